if_fetch_ctrl: RTL

// Consumer side of the IF-stage PC register. Takes the current fetch PC, runs a
// one-outstanding SRAM-like read on instruction memory, and holds the returned

---
 rtl/if_fetch_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: issues one instruction-memory read at a time for
// the current PC, holds the returned instruction for ID, and stalls the PC
// register until ID accepts. Fetches killed by a flush are never delivered.
module if_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] INST_NOP = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic              id_allowin,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_adel,
  output logic              stall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic              pc_aligned;
  logic              lat_addr;
  logic              ld_mem;
  logic              ld_adel;
  logic              clr_valid;

  assign pc_aligned = (pc[1:0] == 2'b00);

  // State register; reset also cancels any in-flight read (memory resets with us).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, memory request and PC stall; flush takes priority in every state.
  always_comb begin
    state_next = state;
    inst_req   = 1'b0;
    inst_addr  = '0;
    stall      = 1'b1;
    lat_addr   = 1'b0;
    ld_mem     = 1'b0;
    ld_adel    = 1'b0;
    clr_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_REQ;
      end
      S_REQ: begin
        // Address tracks the PC until the memory accepts it.
        inst_addr = pc;
        inst_req  = pc_aligned;
        if (flush) begin
          // An accepted request still returns data that must be swallowed.
          if (pc_aligned && inst_addr_ok) state_next = S_DROP;
        end else if (!pc_aligned) begin
          state_next = S_HOLD;
          ld_adel    = 1'b1;
        end else if (inst_addr_ok) begin
          state_next = S_WAIT;
          lat_addr   = 1'b1;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (flush) begin
            state_next = S_REQ;
          end else begin
            state_next = S_HOLD;
            ld_mem     = 1'b1;
          end
        end else if (flush) begin
          state_next = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_next = S_REQ;
          clr_valid  = 1'b1;
        end else if (id_allowin) begin
          stall      = 1'b0;
          state_next = S_REQ;
          clr_valid  = 1'b1;
        end
      end
      S_DROP: begin
        // Data of the killed fetch is discarded; a flush here changes nothing.
        if (inst_data_ok) state_next = S_REQ;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Accepted address and the instruction slot presented to ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_adel  <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      if (lat_addr) addr_q <= pc;
      if (ld_mem) begin
        inst       <= inst_rdata;
        inst_pc    <= addr_q;
        inst_adel  <= 1'b0;
        inst_valid <= 1'b1;
      end
      if (ld_adel) begin
        inst       <= INST_NOP;
        inst_pc    <= pc;
        inst_adel  <= 1'b1;
        inst_valid <= 1'b1;
      end
      if (clr_valid) inst_valid <= 1'b0;
    end
  end

endmodule
